// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D line-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    typedef logic [LINE_W_DEF-1:0] line_t;

    // Timeout counter width; a disabled timeout (0) still needs a 1-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker: on a tie the requester that did not win last is chosen.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic update_en,
    output logic grant_valid,
    output logic grant_d
);

    req_id_t last_grant_reg;
    req_id_t last_grant_next;
    req_id_t pick;

    // Choose a winner and compute the updated last-grant history.
    always_comb begin
        pick            = REQ_I;
        last_grant_next = last_grant_reg;
        if (req_i && req_d) begin
            pick = (last_grant_reg == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            pick = REQ_D;
        end
        grant_valid = req_i | req_d;
        grant_d     = (pick == REQ_D);
        if (update_en && grant_valid) begin
            last_grant_next = pick;
        end
    end

    // History register; starts at I so D wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= REQ_I;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-memory port between the I-cache and D-cache, one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_we,
    input  logic [LINE_W-1:0] i_req_wdata,
    output logic              i_resp_ready,
    output logic [LINE_W-1:0] i_resp_rdata,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [LINE_W-1:0] d_req_wdata,
    output logic              d_resp_ready,
    output logic [LINE_W-1:0] d_resp_rdata,
    output logic              resp_err,
    output logic              mem_addr_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_data_valid,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_data_ready,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    // Last counter value of BUSY; reaching it without ready aborts the transaction.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_reg, state_next;
    req_id_t           owner_reg, owner_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              we_reg, we_next;
    logic [LINE_W-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;

    logic              grant_valid;
    logic              grant_d;
    logic              timeout_hit;
    logic              capture;
    logic [LINE_W-1:0] capture_data;
    logic [LINE_W-1:0] rdata_reg [2];
    logic              resp_ready_w [2];

    rr_arbiter2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_i      (i_req_valid),
        .req_d      (d_req_valid),
        .update_en  (state_reg == IDLE),
        .grant_valid(grant_valid),
        .grant_d    (grant_d)
    );

    // Completion detection: memory ready always beats a coincident timeout.
    always_comb begin
        timeout_hit  = (TIMEOUT != 0) && (state_reg == BUSY) &&
                       (cnt_reg == CNT_LAST) && !mem_data_ready;
        capture      = (state_reg == BUSY) && (mem_data_ready || timeout_hit);
        capture_data = mem_data_ready ? mem_data_i : '0;
    end

    // Next-state logic plus request latching at the grant cycle.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = BUSY;
                    owner_next = grant_d ? REQ_D : REQ_I;
                    addr_next  = grant_d ? d_req_addr  : i_req_addr;
                    we_next    = grant_d ? d_req_we    : i_req_we;
                    wdata_next = grant_d ? d_req_wdata : i_req_wdata;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                if (mem_data_ready) begin
                    state_next = RESP;
                    err_next   = 1'b0;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched request and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= REQ_I;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Per-requester response path: index 0 is the I-cache, index 1 the D-cache.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            localparam req_id_t ID = (gi == 0) ? REQ_I : REQ_D;

            // Only the owner's return line is updated; the other holds its last value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg[gi] <= '0;
                end else if (capture && (owner_reg == ID)) begin
                    rdata_reg[gi] <= capture_data;
                end
            end

            assign resp_ready_w[gi] = (state_reg == RESP) && (owner_reg == ID);
        end
    endgenerate

    assign i_resp_ready   = resp_ready_w[0];
    assign d_resp_ready   = resp_ready_w[1];
    assign i_resp_rdata   = rdata_reg[0];
    assign d_resp_rdata   = rdata_reg[1];
    assign resp_err       = (state_reg == RESP) && err_reg;
    assign mem_addr_valid = (state_reg == BUSY);
    assign mem_addr       = addr_reg;
    assign mem_data_valid = (state_reg == BUSY) && we_reg;
    assign mem_data_o     = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short (8-cycle) response timeout.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req_valid;
    logic [31:0]  i_req_addr;
    logic         i_req_we;
    logic [511:0] i_req_wdata;
    logic         i_resp_ready;
    logic [511:0] i_resp_rdata;
    logic         d_req_valid;
    logic [31:0]  d_req_addr;
    logic         d_req_we;
    logic [511:0] d_req_wdata;
    logic         d_resp_ready;
    logic [511:0] d_resp_rdata;
    logic         resp_err;
    logic         mem_addr_valid;
    logic [31:0]  mem_addr;
    logic         mem_data_valid;
    logic [511:0] mem_data_o;
    logic         mem_data_ready;
    logic [511:0] mem_data_i;

    int vectors     = 0;
    int miscompares = 0;

    logic [511:0] exp_line;
    logic         exp_d;

    mem_arbiter #(.ADDR_W(32), .LINE_W(512), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .i_req_addr    (i_req_addr),
        .i_req_we      (i_req_we),
        .i_req_wdata   (i_req_wdata),
        .i_resp_ready  (i_resp_ready),
        .i_resp_rdata  (i_resp_rdata),
        .d_req_valid   (d_req_valid),
        .d_req_addr    (d_req_addr),
        .d_req_we      (d_req_we),
        .d_req_wdata   (d_req_wdata),
        .d_resp_ready  (d_resp_ready),
        .d_resp_rdata  (d_resp_rdata),
        .resp_err      (resp_err),
        .mem_addr_valid(mem_addr_valid),
        .mem_addr      (mem_addr),
        .mem_data_valid(mem_data_valid),
        .mem_data_o    (mem_data_o),
        .mem_data_ready(mem_data_ready),
        .mem_data_i    (mem_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0; i_req_we = 1'b0; i_req_wdata = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0;
        mem_data_ready = 1'b0; mem_data_i = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_addr_valid", mem_addr_valid, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_i_ready", i_resp_ready, 1'b0);
        chk("rst_d_ready", d_resp_ready, 1'b0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst_d_rdata", d_resp_rdata, 512'h0);

        // D-only line fill, memory answers 3 cycles after mem_addr_valid
        d_req_valid = 1'b1; d_req_addr = 32'h0000_1040; d_req_we = 1'b0;
        step();
        chk("t1_addr_valid", mem_addr_valid, 1'b1);
        chk("t1_addr", mem_addr, 32'h0000_1040);
        chk("t1_data_valid", mem_data_valid, 1'b0);
        step(); step(); step();
        chk("t1_busy_d_ready", d_resp_ready, 1'b0);
        mem_data_ready = 1'b1; mem_data_i = {64{8'hA5}};
        step();
        chk("t1_d_ready", d_resp_ready, 1'b1);
        chk("t1_d_rdata", d_resp_rdata, {64{8'hA5}});
        chk("t1_i_ready", i_resp_ready, 1'b0);
        chk("t1_err", resp_err, 1'b0);
        chk("t1_resp_addr_valid", mem_addr_valid, 1'b0);
        mem_data_ready = 1'b0; mem_data_i = '0; d_req_valid = 1'b0;
        step();
        chk("t1_idle_d_ready", d_resp_ready, 1'b0);
        chk("t1_rdata_hold", d_resp_rdata, {64{8'hA5}});

        // Simultaneous requests after reset alternate D,I,D,I
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0100;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            step();
            chk("t2_grant_addr", mem_addr, exp_d ? 32'h0000_0200 : 32'h0000_0100);
            exp_line = {16{32'hC0DE_0000 | 32'(k)}};
            mem_data_ready = 1'b1; mem_data_i = exp_line;
            step();
            chk("t2_d_ready", d_resp_ready, exp_d);
            chk("t2_i_ready", i_resp_ready, !exp_d);
            chk("t2_rdata", exp_d ? d_resp_rdata : i_resp_rdata, exp_line);
            mem_data_ready = 1'b0; mem_data_i = '0;
            step();
            chk("t2_idle_addr_valid", mem_addr_valid, 1'b0);
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;

        // D write-back; I requests mid-transaction and waits for D to finish
        d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_we = 1'b1;
        d_req_wdata = {32{16'h1234}};
        step();
        chk("t3_data_valid", mem_data_valid, 1'b1);
        chk("t3_addr", mem_addr, 32'h0000_2000);
        chk("t3_wdata", mem_data_o, {32{16'h1234}});
        d_req_addr = 32'hDEAD_0000; d_req_wdata = {64{8'hEE}};
        i_req_valid = 1'b1; i_req_addr = 32'h0000_3000; i_req_we = 1'b0;
        step(); step();
        chk("t3_hold_addr", mem_addr, 32'h0000_2000);
        chk("t3_hold_wdata", mem_data_o, {32{16'h1234}});
        chk("t3_hold_data_valid", mem_data_valid, 1'b1);
        chk("t3_hold_i_ready", i_resp_ready, 1'b0);
        mem_data_ready = 1'b1; mem_data_i = {16{32'hFFFF_0000}};
        step();
        chk("t3_d_ready", d_resp_ready, 1'b1);
        chk("t3_i_ready", i_resp_ready, 1'b0);
        chk("t3_d_rdata", d_resp_rdata, {16{32'hFFFF_0000}});
        mem_data_ready = 1'b0; mem_data_i = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wdata = '0; d_req_addr = '0;
        step();
        chk("t3_idle_addr_valid", mem_addr_valid, 1'b0);
        step();
        chk("t3_i_grant_addr", mem_addr, 32'h0000_3000);
        chk("t3_i_data_valid", mem_data_valid, 1'b0);

        // Timeout: I transaction above never gets a ready
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("t4_busy_i_ready", i_resp_ready, 1'b0);
            chk("t4_busy_addr_valid", mem_addr_valid, 1'b1);
        end
        step();
        chk("t4_i_ready", i_resp_ready, 1'b1);
        chk("t4_err", resp_err, 1'b1);
        chk("t4_i_rdata", i_resp_rdata, 512'h0);
        chk("t4_addr_valid", mem_addr_valid, 1'b0);
        i_req_valid = 1'b0;
        step();
        chk("t4_idle_err", resp_err, 1'b0);
        chk("t4_idle_i_ready", i_resp_ready, 1'b0);

        // Ready on the last allowed BUSY cycle wins over the timeout
        i_req_valid = 1'b1; i_req_addr = 32'h0000_4000;
        step();
        chk("t4b_addr", mem_addr, 32'h0000_4000);
        repeat (7) step();
        chk("t4b_cycle8_addr_valid", mem_addr_valid, 1'b1);
        mem_data_ready = 1'b1; mem_data_i = {16{32'h5A5A_0001}};
        step();
        chk("t4b_i_ready", i_resp_ready, 1'b1);
        chk("t4b_err", resp_err, 1'b0);
        chk("t4b_i_rdata", i_resp_rdata, {16{32'h5A5A_0001}});
        mem_data_ready = 1'b0; mem_data_i = '0; i_req_valid = 1'b0;
        step();

        // Reset during BUSY aborts with no response; late ready is ignored
        i_req_valid = 1'b1; i_req_addr = 32'h0000_5000;
        step();
        chk("t5_busy", mem_addr_valid, 1'b1);
        rst = 1'b1; i_req_valid = 1'b0;
        step();
        rst = 1'b0;
        chk("t5_addr_valid", mem_addr_valid, 1'b0);
        chk("t5_addr", mem_addr, 32'h0);
        chk("t5_i_ready", i_resp_ready, 1'b0);
        chk("t5_d_ready", d_resp_ready, 1'b0);
        chk("t5_err", resp_err, 1'b0);
        chk("t5_i_rdata", i_resp_rdata, 512'h0);
        mem_data_ready = 1'b1; mem_data_i = {16{32'h7777_7777}};
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_late_i_ready", i_resp_ready, 1'b0);
            chk("t5_late_addr_valid", mem_addr_valid, 1'b0);
            chk("t5_late_i_rdata", i_resp_rdata, 512'h0);
        end
        mem_data_ready = 1'b0; mem_data_i = '0;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_6000;
        step();
        chk("t5_next_addr", mem_addr, 32'h0000_6000);
        mem_data_ready = 1'b1; mem_data_i = {16{32'h0BAD_F00D}};
        step();
        chk("t5_next_d_ready", d_resp_ready, 1'b1);
        chk("t5_next_d_rdata", d_resp_rdata, {16{32'h0BAD_F00D}});
        mem_data_ready = 1'b0; d_req_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 512-bit line-memory port between the instruction cache (I) and the data cache (D).
- Round-robin arbitration; one outstanding memory transaction at a time.
- Latches the winning request and holds the memory-side signals stable until memory responds.
- Returns the line to the winner and enforces a response timeout.

Parameters:
ADDR_W  32  byte-address width
LINE_W  512  cache line width in bits
TIMEOUT  1023  max BUSY cycles before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_valid  in  1  I-cache request; held until i_resp_ready
i_req_addr  in  ADDR_W  I-cache line address
i_req_we  in  1  1 = line write-back, 0 = line fill
i_req_wdata  in  LINE_W  write-back line data
i_resp_ready  out  1  one-cycle completion pulse to I-cache
i_resp_rdata  out  LINE_W  fill data, valid with i_resp_ready
d_req_valid, d_req_addr, d_req_we, d_req_wdata  in  1/ADDR_W/1/LINE_W  D-cache request, same rules as I
d_resp_ready, d_resp_rdata  out  1/LINE_W  D-cache response, same rules as I
resp_err  out  1  pulses with resp_ready when a transaction timed out
mem_addr_valid  out  1  memory transaction active
mem_addr  out  ADDR_W  latched address
mem_data_valid  out  1  latched we (write-back)
mem_data_o  out  LINE_W  latched write data
mem_data_ready  in  1  memory completion pulse
mem_data_i  in  LINE_W  read line, valid with mem_data_ready

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- States: IDLE, BUSY, RESP.
- Reset:
  - State goes to IDLE; timeout counter clears.
  - last_grant resets to I, so D wins the first tie.
  - All outputs reset to 0.
  - A reset during BUSY or RESP aborts the transaction with no response pulse.
- IDLE:
  - If either req_valid is high, pick a winner and go to BUSY next cycle.
  - On pick, latch requester id, addr, we and wdata.
  - Single requester: it wins.
  - Both requesting: the one not equal to last_grant wins; last_grant updates to the winner.
- BUSY:
  - mem_addr_valid=1. mem_addr, mem_data_valid and mem_data_o come from the latches, stable for the whole state.
  - The counter increments each cycle.
  - mem_data_ready=1: register mem_data_i into the winner's resp_rdata and go to RESP.
  - Counter reaches TIMEOUT (TIMEOUT≠0) with no mem_data_ready: go to RESP with rdata=0 and resp_err set.
  - If mem_data_ready arrives on the same cycle as the timeout, the ready wins and there is no error.
- RESP (exactly one cycle):
  - The winner's resp_ready=1; resp_err as set; mem_addr_valid=0.
  - New requests are ignored, so a requester dropping req_valid this cycle is never re-granted.
  - Next state is IDLE.
- Outputs outside RESP: non-winner resp_ready=0 always; resp_rdata holds its last value.
- Latency:
  - Request seen in IDLE at cycle n → mem_addr_valid at n+1.
  - mem_data_ready at cycle m → resp_ready at m+1.
  - Earliest next grant is m+2, so the minimum round trip is 3 cycles.
- Write-back: mem_data_i is ignored but still returned registered; the requester discards it.
- Requests changing while not granted are allowed; only the values at the grant cycle are used.
- mem_data_ready outside BUSY is ignored.
- Counter width is clog2(TIMEOUT+1); it clears on entry to BUSY.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE,BUSY,RESP}
  - requester id enum {REQ_I,REQ_D}
  - ADDR_W/LINE_W defaults
  - line_t typedef
- Sub-module rr_arbiter2: 2-way round-robin picker with last_grant register and update enable.
- FSM, latches and timeout counter stay in mem_arbiter.

Test Plan:
- D-only read 0x0000_1040; memory ready 3 cycles after mem_addr_valid with data 0xA5..A5 → mem_addr=0x0000_1040, mem_data_valid=0, d_resp_ready pulses 1 cycle later with 0xA5..A5, i_resp_ready stays 0.
- I and D request in the same cycle after reset → D granted first, I granted at the next IDLE; alternates D,I,D,I over 4 back-to-back transactions.
- D write-back addr 0x0000_2000, wdata pattern 0x1234…; I requests mid-transaction → mem_data_valid=1 and data stable through BUSY; I is granted only after d_resp_ready.
- TIMEOUT=8, memory never ready → i_resp_ready and resp_err pulse together at cycle 9 of BUSY with rdata=0; the next request proceeds normally.
- rst asserted in BUSY → next cycle state IDLE, all outputs 0, no resp_ready; a later mem_data_ready is ignored.
